// File: rtl/hex_stopwatch_if.sv
// Pin-level bundle between the board top and hex_stopwatch: raw buttons and
// direction switch in, active-low segment drives and status LEDs out.
interface hex_stopwatch_if #(
  parameter int DIGITS = 4
);
  logic                toggleBtn;
  logic                clearBtn;
  logic                dir;
  logic [7*DIGITS-1:0] HEX;
  logic                LEDG;
  logic                wrap;

  modport master (
    output toggleBtn, clearBtn, dir,
    input  HEX, LEDG, wrap
  );

  modport slave (
    input  toggleBtn, clearBtn, dir,
    output HEX, LEDG, wrap
  );
endinterface

// File: rtl/hex_stopwatch.sv
// Debounced BCD stopwatch with run/pause/clear control, up/down counting,
// wrap pulse and registered active-low seven-segment outputs.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | count and prescaler held at zero, stopped
// ST_RUN   | prescaler advancing, count steps on every tick
// ST_PAUSE | count and partial prescaler period frozen
module hex_stopwatch #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 500000,
  parameter int DEBOUNCE = 250000
) (
  input logic             CLOCK_50,
  input logic             reset_n,
  hex_stopwatch_if.slave  io
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Bit 0 carries the toggle button, bit 1 the clear button.
  logic [1:0]            btn_s1, btn_s2;
  logic                  dir_s1, dir_s2;
  logic [1:0]            db, db_d;
  logic [1:0][DB_W-1:0]  db_cnt;
  logic [1:0]            press;
  logic                  tog_press, clr_press;

  state_t                state_q, state_d;
  logic [PS_W-1:0]       pre_q, pre_d;
  logic                  tick;
  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, cnt_step;
  logic                  carry;
  logic                  wrap_q, wrap_d;
  logic [7*DIGITS-1:0]   hex_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1 <= 2'b11;
      btn_s2 <= 2'b11;
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
    end else begin
      btn_s1 <= {io.clearBtn, io.toggleBtn};
      btn_s2 <= btn_s1;
      dir_s1 <= io.dir;
      dir_s2 <= dir_s1;
    end
  end

  // The accepted level flips one edge after the counter has recorded
  // DEBOUNCE consecutive mismatching cycles.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      db     <= 2'b11;
      db_d   <= 2'b11;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
      db_d <= db;
    end
  end

  assign press     = db_d & ~db;
  assign clr_press = press[1];
  assign tog_press = press[0] & ~press[1];

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_press) begin
      state_d = ST_IDLE;
    end else if (tog_press) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Tick is decoded from the current state, so a pause press landing on the
  // terminal prescaler cycle still lets that final step through.
  always_comb begin
    tick  = (state_q == ST_RUN) && (pre_q == PS_LAST);
    pre_d = pre_q;
    if (clr_press || state_q == ST_IDLE) begin
      pre_d = '0;
    end else if (state_q == ST_RUN) begin
      pre_d = tick ? '0 : pre_q + PS_W'(1);
    end
  end

  always_comb begin
    cnt_step = cnt_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (!dir_s2) begin
          if (cnt_q[i] >= 4'd9) begin
            cnt_step[i] = 4'd0;
          end else begin
            cnt_step[i] = cnt_q[i] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (cnt_q[i] == 4'd0) begin
            cnt_step[i] = 4'd9;
          end else begin
            cnt_step[i] = cnt_q[i] - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_press) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d  = cnt_step;
      wrap_d = carry;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      hex_q <= {DIGITS{7'h40}};
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        hex_q[7*i +: 7] <= seg7(cnt_q[i]);
      end
    end
  end

  assign io.HEX  = hex_q;
  assign io.LEDG = (state_q == ST_RUN);
  assign io.wrap = wrap_q;

endmodule

// File: tb/tb_hex_stopwatch.sv
// Directed bench for hex_stopwatch with DIGITS=2, TICK_DIV=4, DEBOUNCE=3:
// a cycle-stepped vector table plus hand-written reset sequences.
module tb_hex_stopwatch;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  hex_stopwatch_if #(.DIGITS(2)) io ();

  hex_stopwatch #(
    .DIGITS  (2),
    .TICK_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .CLOCK_50(clk),
    .reset_n (reset_n),
    .io      (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tog;
    logic        clr;
    logic        dir;
    int          steps;
    logic [13:0] hex;
    logic        ledg;
    logic        wrap;
  } vec_t;

  localparam int NV = 28;
  vec_t  vecs [NV];
  string names [NV];
  int    nv_fill;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0:       seg = 7'h40;
      1:       seg = 7'h79;
      2:       seg = 7'h24;
      3:       seg = 7'h30;
      8:       seg = 7'h00;
      9:       seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] hx(input int tens, input int ones);
    hx = {seg(tens), seg(ones)};
  endfunction

  task automatic add(input logic tog, input logic clr, input logic dir, input int steps,
                     input logic [13:0] hex, input logic ledg, input logic wrap, input string nm);
    vecs[nv_fill].tog   = tog;
    vecs[nv_fill].clr   = clr;
    vecs[nv_fill].dir   = dir;
    vecs[nv_fill].steps = steps;
    vecs[nv_fill].hex   = hex;
    vecs[nv_fill].ledg  = ledg;
    vecs[nv_fill].wrap  = wrap;
    names[nv_fill]      = nm;
    nv_fill++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [13:0] eh, input logic el, input logic ew);
    n_vec++;
    if (io.HEX !== eh || io.LEDG !== el || io.wrap !== ew) begin
      n_bad++;
      $display("FAIL %s: got HEX=%h LEDG=%b wrap=%b, want HEX=%h LEDG=%b wrap=%b",
               nm, io.HEX, io.LEDG, io.wrap, eh, el, ew);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    nv_fill = 0;

    // Bounce: two low cycles are rejected.
    add(0, 1, 0,   2, hx(0,0), 0, 0, "bounce_lo");
    add(1, 1, 0,  10, hx(0,0), 0, 0, "bounce_rej");
    // Held press: RUN exactly 6 edges after the first low sample.
    add(0, 1, 0,   6, hx(0,0), 0, 0, "press_pre");
    add(0, 1, 0,   1, hx(0,0), 1, 0, "press_run");
    // Count up: first step TICK_DIV edges after entering RUN, HEX lags one edge.
    add(1, 1, 0,   3, hx(0,0), 1, 0, "pre_first");
    add(1, 1, 0,   1, hx(0,0), 1, 0, "step1_lag");
    add(1, 1, 0,   1, hx(0,1), 1, 0, "step1_hex");
    add(1, 1, 0,  35, hx(0,9), 1, 0, "cnt9");
    add(1, 1, 0,   1, hx(1,0), 1, 0, "cnt10");
    // Pause press lands in the cycle the prescaler holds 2.
    add(1, 1, 0,   3, hx(1,0), 1, 0, "cnt10b");
    add(0, 1, 0,   6, hx(1,2), 1, 0, "pause_pre");
    add(0, 1, 0,   1, hx(1,2), 0, 0, "pause");
    add(1, 1, 0,  20, hx(1,2), 0, 0, "pause_hold");
    // Resume: the frozen partial period finishes one edge after RUN.
    add(0, 1, 0,   7, hx(1,2), 1, 0, "resume");
    add(1, 1, 0,   1, hx(1,2), 1, 0, "resume_lag");
    add(1, 1, 0,   1, hx(1,3), 1, 0, "resume_step");
    // Up wrap 99 -> 00.
    add(1, 1, 0, 344, hx(9,9), 1, 0, "cnt99");
    add(1, 1, 0,   2, hx(9,9), 1, 0, "pre_wrap");
    add(1, 1, 0,   1, hx(9,9), 1, 1, "wrap_up");
    add(1, 1, 0,   1, hx(0,0), 1, 0, "wrap_up_end");
    // Down wrap 00 -> 99 after dir change.
    add(1, 1, 1,   3, hx(0,0), 1, 1, "wrap_dn");
    add(1, 1, 1,   1, hx(9,9), 1, 0, "wrap_dn_hex");
    // Clear and toggle pressed together; clear lands on a tick edge.
    add(0, 0, 1,   6, hx(9,8), 1, 0, "clr_pre");
    add(0, 0, 1,   1, hx(9,8), 0, 0, "clr_idle");
    add(0, 0, 1,   1, hx(0,0), 0, 0, "clr_hex");
    add(1, 1, 1,   8, hx(0,0), 0, 0, "clr_hold");
    // Run again counting down so the reset test starts from a non-zero display.
    add(0, 1, 1,   7, hx(0,0), 1, 0, "rerun");
    add(1, 1, 1,   6, hx(9,9), 1, 0, "rerun_dn");

    io.toggleBtn = 1'b1;
    io.clearBtn  = 1'b1;
    io.dir       = 1'b0;
    reset_n      = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async", hx(0,0), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (3) step();
    check("reset_idle", hx(0,0), 1'b0, 1'b0);

    for (int v = 0; v < nv_fill; v++) begin
      io.toggleBtn = vecs[v].tog;
      io.clearBtn  = vecs[v].clr;
      io.dir       = vecs[v].dir;
      for (int s = 0; s < vecs[v].steps; s++) step();
      check(names[v], vecs[v].hex, vecs[v].ledg, vecs[v].wrap);
    end

    // Reset asserted mid-RUN must take effect without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_run", hx(0,0), 1'b0, 1'b0);
    #2;
    reset_n = 1'b1;
    repeat (10) step();
    check("reset_after", hx(0,0), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
